// File: rtl/riscv_core_pkg.sv
// Shared types and constants for the RV32I core pipeline.
package riscv_core_pkg;

  localparam int          XLEN      = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;  // addi x0,x0,0

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/fetch_if_id_reg.sv
// IF/ID pipeline register: flush beats enable, and flush keeps the PC fields.
module fetch_if_id_reg
  import riscv_core_pkg::*;
#(
  parameter logic [XLEN-1:0] NOP = riscv_core_pkg::NOP_INSTR
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            en_i,
  input  logic            flush_i,
  input  logic [XLEN-1:0] instr_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic [XLEN-1:0] pc_plus4_i,
  output logic            valid_o,
  output logic [XLEN-1:0] instr_o,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] pc_plus4_o
);

  logic            valid_q;
  logic [XLEN-1:0] instr_q, pc_q, pc_plus4_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q    <= 1'b0;
      instr_q    <= NOP;
      pc_q       <= '0;
      pc_plus4_q <= '0;
    end else if (flush_i) begin
      valid_q <= 1'b0;
      instr_q <= NOP;
    end else if (en_i) begin
      valid_q    <= 1'b1;
      instr_q    <= instr_i;
      pc_q       <= pc_i;
      pc_plus4_q <= pc_plus4_i;
    end
  end

  assign valid_o    = valid_q;
  assign instr_o    = instr_q;
  assign pc_o       = pc_q;
  assign pc_plus4_o = pc_plus4_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC register, next-PC selection, range/alignment checks
// and the RUN/HALT fault machine feeding the IF/ID register.
module fetch_stage
  import riscv_core_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000,
  parameter int              IMEM_WORDS = 1024,
  parameter logic [XLEN-1:0] NOP_INSTR  = riscv_core_pkg::NOP_INSTR
) (
  input  logic            clk,
  input  logic            reset,
  output logic [XLEN-1:0] imem_addr,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            stall,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_target,
  output logic            id_valid,
  output logic [XLEN-1:0] id_instr,
  output logic [XLEN-1:0] id_pc,
  output logic [XLEN-1:0] id_pc_plus4,
  output logic            fetch_fault
);

  localparam logic [XLEN-1:0] PC_LIMIT = XLEN'(IMEM_WORDS * 4);

  fetch_state_t    state_q;
  logic [XLEN-1:0] pc_q, pc_plus4;
  logic            fault_q;
  logic            run, tgt_bad, fault_now, flush, en;

  assign pc_plus4  = pc_q + 32'd4;
  assign run       = (state_q == RUN);
  assign tgt_bad   = (redirect_target[1:0] != 2'b00) || (redirect_target >= PC_LIMIT);
  // A legal redirect away from an out-of-range PC is not a fault.
  assign fault_now = run && (redirect_valid ? tgt_bad : (pc_q >= PC_LIMIT));
  assign flush     = run && (fault_now || redirect_valid);
  assign en        = run && !stall;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RUN;
      pc_q    <= RESET_PC;
      fault_q <= 1'b0;
    end else begin
      case (state_q)
        RUN: begin
          if (fault_now) begin
            state_q <= HALT;
            fault_q <= 1'b1;
          end else if (redirect_valid) begin
            pc_q <= redirect_target;
          end else if (!stall) begin
            pc_q <= pc_plus4;
          end
        end
        HALT: ;
        default: state_q <= HALT;
      endcase
    end
  end

  fetch_if_id_reg #(.NOP(NOP_INSTR)) u_if_id (
    .clk        (clk),
    .reset      (reset),
    .en_i       (en),
    .flush_i    (flush),
    .instr_i    (imem_rdata),
    .pc_i       (pc_q),
    .pc_plus4_i (pc_plus4),
    .valid_o    (id_valid),
    .instr_o    (id_instr),
    .pc_o       (id_pc),
    .pc_plus4_o (id_pc_plus4)
  );

  assign imem_addr   = pc_q;
  assign fetch_fault = fault_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed plus randomized bench for fetch_stage against a cycle-level
// behavioural model of the fetch rules and a word-array instruction memory.
module tb_fetch_stage;

  localparam int          WORDS = 1024;
  localparam logic [31:0] LIMIT = 32'(WORDS * 4);
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] imem_addr, imem_rdata;
  logic        stall, redirect_valid;
  logic [31:0] redirect_target;
  logic        id_valid;
  logic [31:0] id_instr, id_pc, id_pc_plus4;
  logic        fetch_fault;

  logic [31:0] mem [WORDS];

  int n_tests = 0;
  int n_fail  = 0;

  // model state
  logic [31:0] m_pc, m_instr, m_idpc, m_idpc4;
  logic        m_valid, m_fault;

  fetch_stage dut (
    .clk             (clk),
    .reset           (reset),
    .imem_addr       (imem_addr),
    .imem_rdata      (imem_rdata),
    .stall           (stall),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .id_valid        (id_valid),
    .id_instr        (id_instr),
    .id_pc           (id_pc),
    .id_pc_plus4     (id_pc_plus4),
    .fetch_fault     (fetch_fault)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    logic [31:0] w;
    w = a >> 2;
    if (a < LIMIT) return mem[w[9:0]];
    return 32'h0;
  endfunction

  assign imem_rdata = reset ? 32'h0 : mem_rd(imem_addr);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance the model by one clock using the inputs currently applied.
  task automatic model_step();
    logic bad;
    if (reset) begin
      m_pc = 32'h0; m_valid = 1'b0; m_instr = NOP;
      m_idpc = 32'h0; m_idpc4 = 32'h0; m_fault = 1'b0;
    end else if (!m_fault) begin
      if (redirect_valid)
        bad = (redirect_target % 4 != 0) || (redirect_target >= LIMIT);
      else
        bad = (m_pc >= LIMIT);
      if (bad) begin
        m_fault = 1'b1; m_valid = 1'b0; m_instr = NOP;
      end else if (redirect_valid) begin
        m_pc = redirect_target; m_valid = 1'b0; m_instr = NOP;
      end else if (!stall) begin
        m_instr = mem_rd(m_pc); m_idpc = m_pc; m_idpc4 = m_pc + 4;
        m_valid = 1'b1; m_pc = m_pc + 4;
      end
    end
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    chk("imem_addr",   imem_addr,          m_pc);
    chk("id_valid",    32'(id_valid),      32'(m_valid));
    chk("id_instr",    id_instr,           m_instr);
    chk("id_pc",       id_pc,              m_idpc);
    chk("id_pc_plus4", id_pc_plus4,        m_idpc4);
    chk("fetch_fault", 32'(fetch_fault),   32'(m_fault));
  endtask

  task automatic drive(input logic rst, input logic st, input logic rv, input logic [31:0] tgt);
    reset = rst; stall = st; redirect_valid = rv; redirect_target = tgt;
  endtask

  initial begin
    for (int i = 0; i < WORDS; i++) mem[i] = $urandom;
    mem[0] = 32'h0040_0293;
    mem[1] = 32'h0060_0313;
    mem[2] = 32'h0062_8433;

    drive(1, 0, 0, 0);
    cycle(); cycle();
    chk("rst_valid", 32'(id_valid), 32'd0);
    chk("rst_instr", id_instr, NOP);
    chk("rst_addr",  imem_addr, 32'h0);
    chk("rst_fault", 32'(fetch_fault), 32'd0);

    // sequential fetch
    drive(0, 0, 0, 0);
    cycle();
    chk("seq1_pc", id_pc, 32'h0);
    chk("seq1_instr", id_instr, 32'h0040_0293);
    cycle();
    chk("seq2_pc", id_pc, 32'h4);
    chk("seq2_instr", id_instr, 32'h0060_0313);
    chk("seq2_pc4", id_pc_plus4, 32'h8);

    // stall at pc=8 for three cycles
    drive(0, 1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("stall_addr", imem_addr, 32'h8);
      chk("stall_idpc", id_pc, 32'h4);
    end
    drive(0, 0, 0, 0);
    cycle();
    chk("unstall_pc", id_pc, 32'h8);
    chk("unstall_instr", id_instr, 32'h0062_8433);
    cycle();
    chk("unstall_pc2", id_pc, 32'hC);

    // redirect overrides stall
    drive(0, 1, 1, 32'h20);
    cycle();
    chk("redir_valid", 32'(id_valid), 32'd0);
    chk("redir_instr", id_instr, NOP);
    chk("redir_addr", imem_addr, 32'h20);
    drive(0, 0, 0, 0);
    cycle();
    chk("redir_idpc", id_pc, 32'h20);
    chk("redir_v1", 32'(id_valid), 32'd1);

    // misaligned redirect -> halt
    drive(0, 0, 1, 32'h22);
    cycle();
    chk("mis_fault", 32'(fetch_fault), 32'd1);
    chk("mis_valid", 32'(id_valid), 32'd0);
    chk("mis_addr", imem_addr, 32'h24);
    drive(0, 0, 1, 32'h0);
    cycle();
    chk("halt_ignore", imem_addr, 32'h24);
    drive(1, 0, 0, 0);
    cycle();
    chk("halt_clr", 32'(fetch_fault), 32'd0);
    chk("halt_rst_addr", imem_addr, 32'h0);
    drive(0, 0, 0, 0);
    cycle();
    chk("restart_pc", id_pc, 32'h0);

    // range fault at end of memory
    drive(0, 0, 1, 32'hFFC);
    cycle();
    chk("range_addr", imem_addr, 32'hFFC);
    drive(0, 0, 0, 0);
    cycle();
    chk("range_last_pc", id_pc, 32'hFFC);
    chk("range_last_instr", id_instr, mem[1023]);
    chk("range_addr2", imem_addr, 32'h1000);
    cycle();
    chk("range_fault", 32'(fetch_fault), 32'd1);

    // reset mid-stream at pc=0x10
    drive(1, 0, 0, 0);
    cycle();
    drive(0, 0, 0, 0);
    for (int i = 0; i < 4; i++) cycle();
    chk("mid_at10", imem_addr, 32'h10);
    drive(1, 0, 0, 0);
    cycle();
    chk("mid_addr", imem_addr, 32'h0);
    chk("mid_valid", 32'(id_valid), 32'd0);
    chk("mid_instr", id_instr, NOP);
    drive(0, 0, 0, 0);
    cycle();
    chk("mid_first", id_pc, 32'h0);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      logic        rst, st, rv;
      logic [31:0] tgt;
      int          r;
      rst = ($urandom_range(0, 99) < (m_fault ? 25 : 2));
      st  = ($urandom_range(0, 99) < 25);
      rv  = ($urandom_range(0, 99) < 15);
      r   = $urandom_range(0, 9);
      if (r < 8)       tgt = 32'($urandom_range(0, WORDS - 1)) * 4;
      else if (r == 8) tgt = (32'($urandom_range(0, WORDS - 1)) * 4) | 32'($urandom_range(1, 3));
      else             tgt = LIMIT + 32'($urandom_range(0, 4096)) * 4;
      if (rv && r < 8 && $urandom_range(0, 9) == 0) tgt = LIMIT - 4;
      drive(rst, st, rv, tgt);
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage of the RV32I core, directly upstream of the instruction memory.
- Owns the program counter and drives the memory word address.
- Captures the combinational read data into an IF/ID pipeline register for the decoder.
- Handles hazard-unit stalls, branch/jump redirects with a one-slot flush, and a sticky fetch-fault halt.

Parameters:
- RESET_PC, 32'h00000000, PC value loaded on reset.
- IMEM_WORDS, 1024, instruction memory depth in 32-bit words; byte range is 0 to IMEM_WORDS*4-1.
- NOP_INSTR, 32'h00000013, instruction injected on flush or bubble (addi x0,x0,0).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset; also routed to the instruction memory.
- imem_addr  output  32  byte address to the instruction memory A input; always equals the PC register.
- imem_rdata  input  32  instruction memory RD; combinational in the same cycle.
- stall  input  1  hazard unit request to hold the PC and IF/ID registers.
- redirect_valid  input  1  taken branch or jump this cycle.
- redirect_target  input  32  byte address of the new PC.
- id_valid  output  1  IF/ID register holds a real instruction.
- id_instr  output  32  IF/ID instruction.
- id_pc  output  32  PC of id_instr.
- id_pc_plus4  output  32  id_pc + 4, for JAL/JALR link.
- fetch_fault  output  1  sticky error flag; core is halted while set.

Behaviour:
- State machine: RUN, HALT. On reset, state = RUN.
- Reset values:
  - pc = RESET_PC, id_valid = 0, id_instr = NOP_INSTR.
  - id_pc = 0, id_pc_plus4 = 0, fetch_fault = 0.
- imem_addr = pc, combinational. The memory reads on imem_addr[31:2], so the instruction at pc reaches id_* on the next rising edge. Latency is 1 cycle.
- RUN state, priority from highest to lowest:
  1. Fault check:
     - A fault is raised by (redirect_valid and redirect_target[1:0] != 0), or by (redirect_valid and redirect_target >= IMEM_WORDS*4).
     - A fault is also raised with no redirect when pc >= IMEM_WORDS*4.
     - On fault: fetch_fault <= 1, state <= HALT, id_valid <= 0, id_instr <= NOP_INSTR, pc held.
  2. redirect_valid with a legal target:
     - pc <= redirect_target, id_valid <= 0, id_instr <= NOP_INSTR; id_pc and id_pc_plus4 hold.
     - Applies even if stall = 1 (redirect overrides stall).
  3. stall = 1: pc and all id_* hold their values.
  4. Normal cycle:
     - id_instr <= imem_rdata, id_pc <= pc, id_pc_plus4 <= pc + 4, id_valid <= 1.
     - pc <= pc + 4.
- HALT state:
  - pc and id_* hold; id_valid = 0; fetch_fault = 1.
  - stall and redirect are ignored; only reset leaves HALT.
- Arithmetic:
  - All PC math is 32-bit modulo 2^32; there is no carry out.
  - A wrap from 32'hFFFFFFFC to 0 is unreachable because the range check faults first.
- Reset asserted mid-stream wins over everything that cycle. The in-flight id_* contents are discarded and the first fetch after release is RESET_PC.
- While reset is high the memory returns 0. The fetch never captures in that cycle because the reset branch has priority.
- Simultaneous stall and redirect is treated as a redirect (flush).
- A stall that lasts N cycles is lossless: after release, the next id_pc equals the held pc.

Decomposition:
- Package riscv_core_pkg:
  - NOP_INSTR localparam.
  - fetch_state_t enum {RUN, HALT}.
  - XLEN = 32.
- Sub-module fetch_if_id_reg:
  - Contents: the id_valid, id_instr, id_pc and id_pc_plus4 registers.
  - Controls: enable (= not stall) and flush inputs.
  - Reset: synchronous, active-high.
  - Reused later for the ID/EX register pattern.
- fetch_stage keeps the PC register, the next-PC mux, the range checks and the state machine.

Test Plan:
- Sequential fetch:
  - Memory preloaded with 0x00400293, 0x00600313, 0x00628433 at words 0..2; release reset.
  - Edge 1: id_pc=0, id_instr=0x00400293.
  - Edge 2: id_pc=4, id_instr=0x00600313, id_pc_plus4=8.
  - Edge 3: id_pc=8, id_instr=0x00628433.
- Stall: hold stall=1 for 3 cycles at pc=8.
  - imem_addr stays 8 and id_* stays unchanged.
  - After release, next id_pc=8, then 12.
- Redirect: redirect_valid=1, target=0x20, with stall=1 in the same cycle.
  - Next edge: id_valid=0, id_instr=0x00000013, imem_addr=0x20.
  - Following edge: id_pc=0x20, id_valid=1.
- Misaligned redirect: target=0x22.
  - fetch_fault=1, id_valid=0, pc unchanged.
  - A later legal redirect to 0x0 is ignored.
  - Asserting reset clears the fault and restarts at 0.
- Range fault: redirect to 0xFFC, then run.
  - Instruction at 0xFFC is delivered.
  - Next cycle pc=0x1000, which triggers fetch_fault=1.
- Reset mid-stream: assert reset at pc=0x10.
  - Next edge: pc=0, id_valid=0, id_instr=NOP_INSTR.
  - First id_pc after release = 0.
